// File: rtl/pixel_uart_tx_pkg.sv
// Shared constants for the pixel UART streamer: FSM encodings, frame header bytes
// and default timing/frame parameters.
package pixel_uart_tx_pkg;

  localparam int DEF_CLK_FREQ   = 40000000;
  localparam int DEF_BAUD       = 115200;
  localparam int DEF_IMAGE_SIZE = 76800;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR     = 3'd1;
  localparam logic [2:0] ST_FETCH   = 3'd2;
  localparam logic [2:0] ST_LATCH   = 3'd3;
  localparam logic [2:0] ST_SEND_HI = 3'd4;
  localparam logic [2:0] ST_SEND_LO = 3'd5;

  localparam logic [7:0] HDR_BYTE0 = 8'h01;
  localparam logic [7:0] HDR_BYTE1 = 8'hFE;

endpackage

// File: rtl/pixel_uart_tx_byte_tx.sv
// 8N1 byte serializer. done fires in the last cycle of the stop bit, where a new
// start is accepted so consecutive bytes leave no idle gap on the line.
module uart_byte_tx #(
  parameter int BIT_DIV = 347
) (
  input  logic       S_CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       txd,
  output logic       busy,
  output logic       done
);
  localparam int CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_DIV - 1);

  logic          active_reg;
  logic [CW-1:0] baud_cnt_reg;
  logic [3:0]    bit_cnt_reg;
  logic [8:0]    shift_reg;
  logic          txd_reg;
  logic          last_cycle;

  assign last_cycle = active_reg && (bit_cnt_reg == 4'd9) && (baud_cnt_reg == BAUD_LAST);
  assign done = last_cycle;
  assign busy = active_reg && !last_cycle;
  assign txd  = txd_reg;

  // shift_reg holds the data bits followed by the stop bit; the start bit is driven directly
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      active_reg   <= 1'b0;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= 4'd0;
      shift_reg    <= '0;
      txd_reg      <= 1'b1;
    end else if (start && !busy) begin
      active_reg   <= 1'b1;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= 4'd0;
      shift_reg    <= {1'b1, tx_byte};
      txd_reg      <= 1'b0;
    end else if (active_reg) begin
      if (baud_cnt_reg == BAUD_LAST) begin
        baud_cnt_reg <= '0;
        if (bit_cnt_reg == 4'd9) begin
          active_reg <= 1'b0;
          txd_reg    <= 1'b1;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
          txd_reg     <= shift_reg[0];
          shift_reg   <= {1'b1, shift_reg[8:1]};
        end
      end else begin
        baud_cnt_reg <= baud_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_uart_tx.sv
// Streams 16-bit pixels from a non-showahead FIFO over UART, high byte first.
// Define FRAME_HEADER_EN to prefix every frame with the bytes 01 FE.
module pixel_uart_tx
  import pixel_uart_tx_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD       = DEF_BAUD,
  parameter int IMAGE_SIZE = DEF_IMAGE_SIZE
) (
  input  logic        S_CLK,
  input  logic        RST_N,
  input  logic [8:0]  r_usedw,
  output logic        r_req,
  input  logic [15:0] r_data,
  output logic        uart_txd,
  output logic        tx_busy,
  output logic        frame_done
);
  localparam int BIT_DIV = CLK_FREQ / BAUD;
  localparam int PIX_W   = $clog2(IMAGE_SIZE + 1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(IMAGE_SIZE - 1);

  logic [2:0]       state_reg, state_next;
  logic [PIX_W-1:0] pix_cnt_reg;
  logic [15:0]      hold_reg;
  logic             r_req_reg, frame_done_reg;
  logic             tx_start, tx_done, byte_busy, byte_idle, last_pix;
  logic [7:0]       tx_data;
`ifdef FRAME_HEADER_EN
  logic             hdr_idx_reg;
`endif

  assign byte_idle  = !byte_busy && !tx_done;
  assign last_pix   = (pix_cnt_reg == LAST_PIX);
  assign r_req      = r_req_reg;
  assign frame_done = frame_done_reg;
  assign tx_busy    = (state_reg != ST_IDLE);

  always_comb begin
    state_next = state_reg;
    tx_start   = 1'b0;
    tx_data    = hold_reg[15:8];
    case (state_reg)
      ST_IDLE: begin
        if (r_usedw != 9'd0) begin
          state_next = ST_FETCH;
`ifdef FRAME_HEADER_EN
          if (pix_cnt_reg == '0) begin
            state_next = ST_HDR;
            tx_start   = 1'b1;
            tx_data    = HDR_BYTE0;
          end
`endif
        end
      end
`ifdef FRAME_HEADER_EN
      ST_HDR: begin
        if (tx_done) begin
          if (!hdr_idx_reg) begin
            tx_start = 1'b1;
            tx_data  = HDR_BYTE1;
          end else begin
            state_next = ST_FETCH;
          end
        end
      end
`endif
      ST_FETCH: state_next = ST_LATCH;
      ST_LATCH: state_next = ST_SEND_HI;
      ST_SEND_HI: begin
        // first cycle here the serializer is idle; the low byte chains on done
        if (byte_idle) begin
          tx_start = 1'b1;
        end else if (tx_done) begin
          tx_start   = 1'b1;
          tx_data    = hold_reg[7:0];
          state_next = ST_SEND_LO;
        end
      end
      ST_SEND_LO: begin
        if (tx_done) begin
          if (last_pix || r_usedw == 9'd0) state_next = ST_IDLE;
          else                             state_next = ST_FETCH;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg      <= ST_IDLE;
      pix_cnt_reg    <= '0;
      hold_reg       <= 16'd0;
      r_req_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
`ifdef FRAME_HEADER_EN
      hdr_idx_reg    <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      r_req_reg      <= (state_next == ST_FETCH);
      frame_done_reg <= (state_reg == ST_SEND_LO) && tx_done && last_pix;
      if (state_reg == ST_LATCH) hold_reg <= r_data;
      if (state_reg == ST_SEND_LO && tx_done)
        pix_cnt_reg <= last_pix ? '0 : pix_cnt_reg + 1'b1;
`ifdef FRAME_HEADER_EN
      if (state_reg == ST_HDR && tx_done) hdr_idx_reg <= !hdr_idx_reg;
`endif
    end
  end

  uart_byte_tx #(.BIT_DIV(BIT_DIV)) u_byte_tx (
    .S_CLK   (S_CLK),
    .RST_N   (RST_N),
    .start   (tx_start),
    .tx_byte (tx_data),
    .txd     (uart_txd),
    .busy    (byte_busy),
    .done    (tx_done)
  );

endmodule

// File: tb/tb_pixel_uart_tx.sv
// Scoreboard bench for pixel_uart_tx: FIFO model feeds words, a line decoder checks
// each received byte and frame_done against expectations built from pushed pixels.
module tb_pixel_uart_tx;
  localparam int CLK_FREQ   = 40;
  localparam int BAUD       = 10;
  localparam int BIT_DIV    = CLK_FREQ / BAUD;
  localparam int IMAGE_SIZE = 2;
`ifdef FRAME_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  logic        S_CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [8:0]  r_usedw = 9'd0;
  logic        r_req;
  logic [15:0] r_data = 16'd0;
  logic        uart_txd, tx_busy, frame_done;

  int tests_run = 0;
  int tests_failed = 0;
  int bytes_seen = 0;
  int exp_total = 0;
  int model_pix = 0;
  logic [15:0] fifo_q[$];
  logic [7:0]  exp_bytes[$];
  int          exp_frames[$];

  pixel_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .IMAGE_SIZE(IMAGE_SIZE)) dut (
    .S_CLK      (S_CLK),
    .RST_N      (RST_N),
    .r_usedw    (r_usedw),
    .r_req      (r_req),
    .r_data     (r_data),
    .uart_txd   (uart_txd),
    .tx_busy    (tx_busy),
    .frame_done (frame_done)
  );

  always #5 S_CLK = ~S_CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Non-showahead FIFO: data appears the cycle after the request
  always @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      fifo_q.delete();
      r_usedw <= 9'd0;
    end else begin
      if (r_req) begin
        check("r_req_with_data", {31'd0, fifo_q.size() != 0}, 32'd1);
        if (fifo_q.size() != 0) r_data <= fifo_q.pop_front();
      end
      r_usedw <= 9'(fifo_q.size());
    end
  end

  // Line decoder: capture 40 cycles per byte, require every bit flat for BIT_DIV cycles
  initial begin : rx_mon
    logic [39:0] s;
    logic        aborted, flat;
    logic [7:0]  b;
    forever begin
      @(negedge S_CLK);
      if (RST_N === 1'b1 && uart_txd === 1'b0) begin
        s = '0;
        aborted = 1'b0;
        for (int c = 1; c < 10 * BIT_DIV; c++) begin
          @(negedge S_CLK);
          if (RST_N !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          s[c] = uart_txd;
        end
        if (!aborted) begin
          flat = 1'b1;
          for (int k = 0; k < 10; k++)
            for (int j = 1; j < BIT_DIV; j++)
              if (s[k*BIT_DIV+j] !== s[k*BIT_DIV]) flat = 1'b0;
          check("bit_timing", {31'd0, flat}, 32'd1);
          check("stop_bit", {31'd0, s[9*BIT_DIV]}, 32'd1);
          for (int k = 0; k < 8; k++) b[k] = s[(k+1)*BIT_DIV];
          $display("[TB] rx byte %02h", b);
          if (exp_bytes.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected_byte: got %02h required none", b);
          end else begin
            check("rx_byte", {24'd0, b}, {24'd0, exp_bytes.pop_front()});
          end
          bytes_seen++;
        end
      end
    end
  end

  always @(negedge S_CLK) begin
    if (RST_N === 1'b1 && frame_done === 1'b1) begin
      $display("[TB] frame_done after %0d bytes", bytes_seen);
      if (exp_frames.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL spurious_frame_done: got pulse at byte %0d required none", bytes_seen);
      end else begin
        check("frame_done_pos", bytes_seen, exp_frames.pop_front());
      end
    end
  end

  // Reference: header ahead of pixel 0 of each frame, then high byte, low byte
  task automatic push_word(input logic [15:0] w);
    @(negedge S_CLK);
    fifo_q.push_back(w);
    if (HDR_EN && model_pix == 0) begin
      exp_bytes.push_back(8'h01);
      exp_bytes.push_back(8'hFE);
      exp_total += 2;
    end
    exp_bytes.push_back(w[15:8]);
    exp_bytes.push_back(w[7:0]);
    exp_total += 2;
    model_pix = (model_pix + 1) % IMAGE_SIZE;
    if (model_pix == 0) exp_frames.push_back(exp_total);
    $display("[TB] push pixel %04h", w);
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge S_CLK);
      check("idle_outputs", {29'd0, uart_txd, r_req, tx_busy}, 32'd4);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_bytes.size() != 0 || tx_busy) && n < budget) begin
      @(negedge S_CLK);
      n++;
    end
    check("drain_in_budget", {31'd0, n < budget}, 32'd1);
    repeat (3) @(negedge S_CLK);
    check("frames_pending", exp_frames.size(), 32'd0);
    check("fifo_empty", {23'd0, r_usedw}, 32'd0);
  endtask

  initial begin : watchdog
    #800000;
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin : stim
    int n;
    repeat (3) @(negedge S_CLK);
    check("reset_state", {28'd0, uart_txd, r_req, tx_busy, frame_done}, 32'h8);
    @(posedge S_CLK);
    #2 RST_N = 1'b1;
    check_idle(20);

    // single pixel, then an empty FIFO mid-frame, then the closing pixel
    push_word(16'hA55A);
    drain(1000);
    check_idle(100);
    push_word(16'h5678);
    drain(1000);

    push_word(16'h1234);
    push_word(16'hABCD);
    drain(1000);

    for (int f = 0; f < 4; f++)
      for (int p = 0; p < IMAGE_SIZE; p++) begin
        repeat ($urandom_range(0, 80)) @(negedge S_CLK);
        push_word(16'($urandom));
      end
    drain(3000);

    // reset in the middle of data bit 3 of the first byte of a frame
    push_word(16'($urandom));
    push_word(16'($urandom));
    n = 0;
    while (uart_txd !== 1'b0 && n < 200) begin
      @(negedge S_CLK);
      n++;
    end
    check("tx_started", {31'd0, n < 200}, 32'd1);
    repeat (4 * BIT_DIV + 1) @(negedge S_CLK);
    @(posedge S_CLK);
    #2 RST_N = 1'b0;
    exp_bytes.delete();
    exp_frames.delete();
    model_pix = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge S_CLK);
      check("reset_hold", {28'd0, uart_txd, r_req, tx_busy, frame_done}, 32'h8);
    end
    exp_total = bytes_seen;
    @(posedge S_CLK);
    #2 RST_N = 1'b1;
    push_word(16'($urandom));
    push_word(16'($urandom));
    drain(1500);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
